acc_offload_tracker: RTL and testbench



---
 rtl/acc_offload_tracker.sv | 178 +++++++++++++++++
 tb/tb_acc_offload_tracker.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_offload_tracker.sv
// Requester-side offload tracker: tags core requests with free transaction IDs, registers them
// towards the accelerator interconnect and routes out-of-order responses back to their tag.
module acc_offload_tracker #(
  parameter int unsigned AccAddrWidth   = 5,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TagWidth       = 5,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // Core request
  input  logic                    core_q_valid_i,
  output logic                    core_q_ready_o,
  input  logic [AccAddrWidth-1:0] core_q_addr_i,
  input  logic [DataWidth-1:0]    core_q_arga_i,
  input  logic [DataWidth-1:0]    core_q_argb_i,
  input  logic [DataWidth-1:0]    core_q_argc_i,
  input  logic [31:0]             core_q_op_i,
  input  logic [TagWidth-1:0]     core_q_tag_i,
  // Interconnect request
  output logic                    acc_q_valid_o,
  input  logic                    acc_q_ready_i,
  output logic [AccAddrWidth-1:0] acc_q_addr_o,
  output logic [DataWidth-1:0]    acc_q_arga_o,
  output logic [DataWidth-1:0]    acc_q_argb_o,
  output logic [DataWidth-1:0]    acc_q_argc_o,
  output logic [31:0]             acc_q_op_o,
  output logic [IdWidth-1:0]      acc_q_id_o,
  // Interconnect response
  input  logic                    acc_p_valid_i,
  output logic                    acc_p_ready_o,
  input  logic [IdWidth-1:0]      acc_p_id_i,
  input  logic [DataWidth-1:0]    acc_p_data_i,
  input  logic                    acc_p_error_i,
  // Core writeback
  output logic                    core_p_valid_o,
  input  logic                    core_p_ready_i,
  output logic [TagWidth-1:0]     core_p_tag_o,
  output logic [DataWidth-1:0]    core_p_data_o,
  output logic                    core_p_error_o,
  // Status
  output logic [CntWidth-1:0]     outstanding_o,
  output logic                    stray_rsp_o
);

  logic [MaxOutstanding-1:0] busy_q, busy_d;
  logic [MaxOutstanding-1:0] alloc_mask, free_mask;
  logic [TagWidth-1:0]       tag_q [MaxOutstanding];
  logic [IdWidth-1:0]        alloc_id;
  logic [TagWidth-1:0]       rsp_tag;
  logic                      rsp_hit;
  logic                      req_hs, rsp_hs;
  logic [CntWidth-1:0]       busy_cnt;

  logic                    acc_q_valid_q;
  logic [AccAddrWidth-1:0] acc_q_addr_q;
  logic [DataWidth-1:0]    acc_q_arga_q, acc_q_argb_q, acc_q_argc_q;
  logic [31:0]             acc_q_op_q;
  logic [IdWidth-1:0]      acc_q_id_q;

  logic                 core_p_valid_q;
  logic [TagWidth-1:0]  core_p_tag_q;
  logic [DataWidth-1:0] core_p_data_q;
  logic                 core_p_error_q;
  logic                 stray_q;

  // Lowest clear busy bit wins; scanning downwards leaves the lowest index last.
  always_comb begin
    alloc_id   = '0;
    alloc_mask = '0;
    for (int i = int'(MaxOutstanding) - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_id      = IdWidth'(i);
        alloc_mask    = '0;
        alloc_mask[i] = 1'b1;
      end
    end
  end

  // IDs at or above MaxOutstanding never match, so they fall out as stray.
  always_comb begin
    rsp_hit   = 1'b0;
    rsp_tag   = '0;
    free_mask = '0;
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      if (acc_p_id_i == IdWidth'(i)) begin
        rsp_hit      = busy_q[i];
        rsp_tag      = tag_q[i];
        free_mask[i] = busy_q[i];
      end
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      busy_cnt = busy_cnt + CntWidth'(busy_q[i]);
    end
  end

  assign core_q_ready_o = (!acc_q_valid_q || acc_q_ready_i) && !(&busy_q);
  assign acc_p_ready_o  = !core_p_valid_q || core_p_ready_i;
  assign req_hs         = core_q_valid_i && core_q_ready_o;
  assign rsp_hs         = acc_p_valid_i && acc_p_ready_o;

  // Allocation only ever targets a clear bit and a free only a set one, so they never collide.
  always_comb begin
    busy_d = busy_q;
    if (req_hs) busy_d = busy_d | alloc_mask;
    if (rsp_hs) busy_d = busy_d & ~free_mask;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q         <= '0;
      acc_q_valid_q  <= 1'b0;
      acc_q_addr_q   <= '0;
      acc_q_arga_q   <= '0;
      acc_q_argb_q   <= '0;
      acc_q_argc_q   <= '0;
      acc_q_op_q     <= '0;
      acc_q_id_q     <= '0;
      core_p_valid_q <= 1'b0;
      core_p_tag_q   <= '0;
      core_p_data_q  <= '0;
      core_p_error_q <= 1'b0;
      stray_q        <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      stray_q <= rsp_hs && !rsp_hit;
      if (req_hs) begin
        acc_q_valid_q <= 1'b1;
        acc_q_addr_q  <= core_q_addr_i;
        acc_q_arga_q  <= core_q_arga_i;
        acc_q_argb_q  <= core_q_argb_i;
        acc_q_argc_q  <= core_q_argc_i;
        acc_q_op_q    <= core_q_op_i;
        acc_q_id_q    <= alloc_id;
      end else if (acc_q_ready_i) begin
        acc_q_valid_q <= 1'b0;
      end
      if (rsp_hs) begin
        core_p_valid_q <= rsp_hit;
        if (rsp_hit) begin
          core_p_tag_q   <= rsp_tag;
          core_p_data_q  <= acc_p_data_i;
          core_p_error_q <= acc_p_error_i;
        end
      end else if (core_p_ready_i) begin
        core_p_valid_q <= 1'b0;
      end
    end
  end

  // Tag table needs no reset: entries are only read while their busy bit is set.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      if (req_hs && alloc_mask[i]) tag_q[i] <= core_q_tag_i;
    end
  end

  assign acc_q_valid_o  = acc_q_valid_q;
  assign acc_q_addr_o   = acc_q_addr_q;
  assign acc_q_arga_o   = acc_q_arga_q;
  assign acc_q_argb_o   = acc_q_argb_q;
  assign acc_q_argc_o   = acc_q_argc_q;
  assign acc_q_op_o     = acc_q_op_q;
  assign acc_q_id_o     = acc_q_id_q;
  assign core_p_valid_o = core_p_valid_q;
  assign core_p_tag_o   = core_p_tag_q;
  assign core_p_data_o  = core_p_data_q;
  assign core_p_error_o = core_p_error_q;
  assign outstanding_o  = busy_cnt;
  assign stray_rsp_o    = stray_q;

endmodule

// File: tb/tb_acc_offload_tracker.sv
// Scoreboard bench for acc_offload_tracker: stimulus pushes expected interconnect requests and
// writebacks into queues, a negedge monitor pops and compares on every output handshake.
module tb_acc_offload_tracker;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_q_valid_i, core_q_ready_o;
  logic [4:0]  core_q_addr_i, core_q_tag_i;
  logic [31:0] core_q_arga_i, core_q_argb_i, core_q_argc_i, core_q_op_i;
  logic        acc_q_valid_o, acc_q_ready_i;
  logic [4:0]  acc_q_addr_o, acc_q_id_o;
  logic [31:0] acc_q_arga_o, acc_q_argb_o, acc_q_argc_o, acc_q_op_o;
  logic        acc_p_valid_i, acc_p_ready_o, acc_p_error_i;
  logic [4:0]  acc_p_id_i;
  logic [31:0] acc_p_data_i;
  logic        core_p_valid_o, core_p_ready_i, core_p_error_o;
  logic [4:0]  core_p_tag_o;
  logic [31:0] core_p_data_o;
  logic [2:0]  outstanding_o;
  logic        stray_rsp_o;

  typedef struct {
    logic [4:0]  id;
    logic [4:0]  addr;
    logic [31:0] arga, argb, argc, op;
  } acc_exp_t;

  typedef struct {
    logic [4:0]  tag;
    logic [31:0] data;
    logic        err;
  } wb_exp_t;

  acc_exp_t acc_sb[$];
  wb_exp_t  wb_sb[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int exp_stray  = 0;
  int stray_seen = 0;

  acc_offload_tracker dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .core_q_valid_i(core_q_valid_i),
    .core_q_ready_o(core_q_ready_o),
    .core_q_addr_i (core_q_addr_i),
    .core_q_arga_i (core_q_arga_i),
    .core_q_argb_i (core_q_argb_i),
    .core_q_argc_i (core_q_argc_i),
    .core_q_op_i   (core_q_op_i),
    .core_q_tag_i  (core_q_tag_i),
    .acc_q_valid_o (acc_q_valid_o),
    .acc_q_ready_i (acc_q_ready_i),
    .acc_q_addr_o  (acc_q_addr_o),
    .acc_q_arga_o  (acc_q_arga_o),
    .acc_q_argb_o  (acc_q_argb_o),
    .acc_q_argc_o  (acc_q_argc_o),
    .acc_q_op_o    (acc_q_op_o),
    .acc_q_id_o    (acc_q_id_o),
    .acc_p_valid_i (acc_p_valid_i),
    .acc_p_ready_o (acc_p_ready_o),
    .acc_p_id_i    (acc_p_id_i),
    .acc_p_data_i  (acc_p_data_i),
    .acc_p_error_i (acc_p_error_i),
    .core_p_valid_o(core_p_valid_o),
    .core_p_ready_i(core_p_ready_i),
    .core_p_tag_o  (core_p_tag_o),
    .core_p_data_o (core_p_data_o),
    .core_p_error_o(core_p_error_o),
    .outstanding_o (outstanding_o),
    .stray_rsp_o   (stray_rsp_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, half a cycle before the handshake edge.
  always @(negedge clk) begin
    acc_exp_t ae;
    wb_exp_t  we;
    if (!rst_i) begin
      if (acc_q_valid_o && acc_q_ready_i) begin
        if (acc_sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL acc_q_unexpected: got id %0d, expected no request", acc_q_id_o);
        end else begin
          ae = acc_sb.pop_front();
          check("acc_q_id", acc_q_id_o, ae.id);
          check("acc_q_addr", acc_q_addr_o, ae.addr);
          check("acc_q_arga", acc_q_arga_o, ae.arga);
          check("acc_q_argb", acc_q_argb_o, ae.argb);
          check("acc_q_argc", acc_q_argc_o, ae.argc);
          check("acc_q_op", acc_q_op_o, ae.op);
        end
      end
      if (core_p_valid_o && core_p_ready_i) begin
        if (wb_sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL core_p_unexpected: got tag %0d, expected no writeback", core_p_tag_o);
        end else begin
          we = wb_sb.pop_front();
          check("core_p_tag", core_p_tag_o, we.tag);
          check("core_p_data", core_p_data_o, we.data);
          check("core_p_error", core_p_error_o, we.err);
        end
      end
      if (stray_rsp_o) stray_seen++;
    end
  end

  task automatic send_req(input logic [4:0] addr, input logic [4:0] tag, input logic [31:0] arga,
                          input logic [4:0] exp_id, output int hs_cyc);
    acc_exp_t e;
    e.id = exp_id; e.addr = addr; e.arga = arga;
    e.argb = arga + 32'd1; e.argc = arga + 32'd2; e.op = 32'h33 + 32'(tag);
    acc_sb.push_back(e);
    core_q_valid_i = 1'b1;
    core_q_addr_i  = addr;
    core_q_tag_i   = tag;
    core_q_arga_i  = e.arga;
    core_q_argb_i  = e.argb;
    core_q_argc_i  = e.argc;
    core_q_op_i    = e.op;
    hs_cyc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (core_q_ready_o) hs_cyc = cyc;
      @(posedge clk);
      #1;
      if (hs_cyc >= 0) break;
    end
    core_q_valid_i = 1'b0;
    if (hs_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: got no handshake, expected one for tag %0d", tag);
    end
  endtask

  task automatic send_rsp(input logic [4:0] id, input logic [31:0] data, input logic err,
                          output int hs_cyc);
    acc_p_valid_i = 1'b1;
    acc_p_id_i    = id;
    acc_p_data_i  = data;
    acc_p_error_i = err;
    hs_cyc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (acc_p_ready_o) hs_cyc = cyc;
      @(posedge clk);
      #1;
      if (hs_cyc >= 0) break;
    end
    acc_p_valid_i = 1'b0;
    if (hs_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got no handshake, expected one for id %0d", id);
    end
  endtask

  task automatic push_wb(input logic [4:0] tag, input logic [31:0] data, input logic err);
    wb_exp_t w;
    w.tag = tag; w.data = data; w.err = err;
    wb_sb.push_back(w);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h[4];
    int h5, hr;
    rst_i = 1'b1;
    core_q_valid_i = 1'b0; core_q_addr_i = '0; core_q_tag_i = '0; core_q_op_i = '0;
    core_q_arga_i = '0; core_q_argb_i = '0; core_q_argc_i = '0;
    acc_q_ready_i = 1'b1; core_p_ready_i = 1'b1;
    acc_p_valid_i = 1'b0; acc_p_id_i = '0; acc_p_data_i = '0; acc_p_error_i = 1'b0;
    tick(2);
    rst_i = 1'b0;

    // Reset state
    check("rst_acc_q_valid", acc_q_valid_o, 0);
    check("rst_core_p_valid", core_p_valid_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_stray", stray_rsp_o, 0);
    check("rst_acc_q_id", acc_q_id_o, 0);
    check("rst_core_q_ready", core_q_ready_o, 1);

    // Single request / response
    send_req(5'd2, 5'd7, 32'h11, 5'd0, h[0]);
    check("single_acc_q_valid", acc_q_valid_o, 1);
    check("single_acc_q_id", acc_q_id_o, 0);
    check("single_outstanding", outstanding_o, 1);
    push_wb(5'd7, 32'hCAFE, 1'b0);
    send_rsp(5'd0, 32'hCAFE, 1'b0, hr);
    check("single_core_p_valid", core_p_valid_o, 1);
    check("single_core_p_tag", core_p_tag_o, 7);
    check("single_outstanding_back", outstanding_o, 0);
    tick(2);

    // Fill all IDs back to back, tag = 10 + id
    for (int i = 0; i < 4; i++) send_req(5'(i), 5'(10 + i), 32'h100 * i, 5'(i), h[i]);
    check("b2b_throughput", h[3] - h[0], 3);
    check("full_outstanding", outstanding_o, 4);
    check("full_core_q_ready", core_q_ready_o, 0);

    // Fifth request stalls until id 2 is returned
    fork
      send_req(5'd1, 5'd20, 32'h50, 5'd2, h5);
      begin
        tick(2);
        push_wb(5'd12, 32'h2222, 1'b0);
        send_rsp(5'd2, 32'h2222, 1'b0, hr);
      end
    join
    check("realloc_latency", h5 - hr, 1);

    // Out-of-order returns
    push_wb(5'd13, 32'h3333, 1'b0);
    send_rsp(5'd3, 32'h3333, 1'b0, hr);
    push_wb(5'd10, 32'h1000, 1'b1);
    send_rsp(5'd0, 32'h1000, 1'b1, hr);
    push_wb(5'd11, 32'h1111, 1'b0);
    send_rsp(5'd1, 32'h1111, 1'b0, hr);
    push_wb(5'd20, 32'h2020, 1'b0);
    send_rsp(5'd2, 32'h2020, 1'b0, hr);
    check("ooo_outstanding", outstanding_o, 0);
    tick(2);

    // Stray responses: idle id, then out-of-range id
    check("stray1_acc_p_ready", acc_p_ready_o, 1);
    exp_stray++;
    send_rsp(5'd1, 32'hDEAD, 1'b0, hr);
    check("stray1_pulse", stray_rsp_o, 1);
    check("stray1_no_wb", core_p_valid_o, 0);
    tick(1);
    check("stray1_pulse_end", stray_rsp_o, 0);
    exp_stray++;
    send_rsp(5'd6, 32'hBEEF, 1'b0, hr);
    check("stray6_pulse", stray_rsp_o, 1);
    check("stray6_no_wb", core_p_valid_o, 0);
    tick(1);
    check("stray6_pulse_end", stray_rsp_o, 0);

    // Request-side backpressure
    acc_q_ready_i = 1'b0;
    send_req(5'd3, 5'd5, 32'h55, 5'd0, h[0]);
    for (int i = 0; i < 3; i++) begin
      check("bp_acc_q_valid", acc_q_valid_o, 1);
      check("bp_acc_q_id", acc_q_id_o, 0);
      check("bp_acc_q_arga", acc_q_arga_o, 32'h55);
      check("bp_core_q_ready", core_q_ready_o, 0);
      tick(1);
    end
    acc_q_ready_i = 1'b1;
    tick(1);

    // Writeback backpressure
    core_p_ready_i = 1'b0;
    push_wb(5'd5, 32'hBEEF, 1'b0);
    send_rsp(5'd0, 32'hBEEF, 1'b0, hr);
    for (int i = 0; i < 3; i++) begin
      check("bp_core_p_valid", core_p_valid_o, 1);
      check("bp_core_p_data", core_p_data_o, 32'hBEEF);
      check("bp_acc_p_ready", acc_p_ready_o, 0);
      tick(1);
    end
    core_p_ready_i = 1'b1;
    tick(1);
    check("bp_outstanding", outstanding_o, 0);

    // Reset with three outstanding and a held writeback
    for (int i = 0; i < 4; i++) send_req(5'd4, 5'(1 + i), 32'h700 + i, 5'(i), h[i]);
    core_p_ready_i = 1'b0;
    send_rsp(5'd3, 32'h4444, 1'b0, hr);
    check("pre_rst_outstanding", outstanding_o, 3);
    check("pre_rst_core_p_valid", core_p_valid_o, 1);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    core_p_ready_i = 1'b1;
    check("mid_rst_acc_q_valid", acc_q_valid_o, 0);
    check("mid_rst_core_p_valid", core_p_valid_o, 0);
    check("mid_rst_outstanding", outstanding_o, 0);
    check("mid_rst_stray", stray_rsp_o, 0);
    check("mid_rst_acc_q_id", acc_q_id_o, 0);
    exp_stray++;
    send_rsp(5'd0, 32'h5555, 1'b0, hr);
    check("post_rst_stray", stray_rsp_o, 1);
    check("post_rst_no_wb", core_p_valid_o, 0);
    tick(3);

    check("stray_count", stray_seen, exp_stray);
    check("acc_sb_drained", acc_sb.size(), 0);
    check("wb_sb_drained", wb_sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
